nps_rom_outbuf: RTL

- Stream buffer directly downstream of NPS_rom. It captures the ROM's 24-bit data stream (vi/fi/datai) into a small FIFO.
- It replays the stream to the next stage under a ready handshake, so a stalling consumer does not lose ROM words.
- It preserves the frame-end event (fi) in stream order and reports it on fo.
- It tracks occupancy and flags overflow for debug.

---
 rtl/nps_pkg.sv | 17 +
 rtl/nps_rom_outbuf_if.sv | 27 ++
 rtl/nps_rom_outbuf_fifo_mem.sv | 26 ++
 rtl/nps_rom_outbuf.sv | 129 ++++++++++++
 4 files changed

// File: rtl/nps_pkg.sv
// Shared NPS constants: ROM geometry and the buffered-entry field layout.
// An entry is {mark, last, data}: mark = frame-end marker with no word, last = word closes the frame.
package nps_pkg;

    localparam int NPS_DATA_WIDTH = 24;
    localparam int NPS_ADR_WIDTH  = 9;

    localparam int LAST_BIT    = NPS_DATA_WIDTH;
    localparam int MARK_BIT    = NPS_DATA_WIDTH + 1;
    localparam int ENTRY_WIDTH = NPS_DATA_WIDTH + 2;

    // Returns {mark, last} for a write caused by a word and/or a frame-end edge.
    function automatic logic [1:0] entry_tag(input logic vi, input logic fi_rise);
        return {~vi & fi_rise, vi & fi_rise};
    endfunction

endpackage

// File: rtl/nps_rom_outbuf_if.sv
// Stream bus between NPS_rom, the output buffer and the downstream consumer.
// master = the environment (ROM side + consumer); slave = the buffer.
interface nps_rom_outbuf_if #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH_LOG2 = 4
);
    logic                  vi;
    logic                  fi;
    logic [DATA_WIDTH-1:0] datai;
    logic                  rdy;
    logic                  vo;
    logic                  fo;
    logic [DATA_WIDTH-1:0] datao;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  ovf;

    modport master (
        output vi, fi, datai, rdy,
        input  vo, fo, datao, count, full, ovf
    );

    modport slave (
        input  vi, fi, datai, rdy,
        output vo, fo, datao, count, full, ovf
    );
endinterface

// File: rtl/nps_rom_outbuf_fifo_mem.sv
// Register-array storage for the output buffer: synchronous write, asynchronous read.
// No reset on the array; the control logic never reads a slot it has not written.
module nps_fifo_mem #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 26
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nps_rom_outbuf.sv
// Buffers the NPS_rom word stream and its frame-end events in a FIFO and replays
// them through a show-ahead output register under a vo/rdy handshake.
module nps_rom_outbuf
    import nps_pkg::*;
#(
    parameter int DATA_WIDTH = NPS_DATA_WIDTH,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            clk,
    input  logic            reset_x,
    nps_rom_outbuf_if.slave bus
);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int CNT_W    = DEPTH_LOG2 + 1;
    localparam int ENTRY_W  = DATA_WIDTH + 2;
    localparam int LAST_POS = DATA_WIDTH + (LAST_BIT - NPS_DATA_WIDTH);
    localparam int MARK_POS = DATA_WIDTH + (MARK_BIT - NPS_DATA_WIDTH);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  fi_prev_q;
    logic                  ovf_q, ovf_d;
    logic                  vo_q, vo_d;
    logic                  fo_q, fo_d;
    logic [DATA_WIDTH-1:0] datao_q, datao_d;

    logic                  fi_rise;
    logic                  wr_req;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  out_free;
    logic                  pop;
    logic                  push;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    rd_entry;

    assign fi_rise    = bus.fi & ~fi_prev_q;
    assign wr_req     = bus.vi | fi_rise;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));

    // The output slot is free when it holds nothing, a marker, or a word being taken now.
    assign out_free = ~vo_q | bus.rdy;
    assign pop      = ~fifo_empty & out_free;
    // A same-cycle pop frees a slot, so a write at full still lands.
    assign push     = wr_req & (~fifo_full | pop);

    always_comb begin
        wr_entry = '0;
        {wr_entry[MARK_POS], wr_entry[LAST_POS]} = entry_tag(bus.vi, fi_rise);
        if (bus.vi) begin
            wr_entry[DATA_WIDTH-1:0] = bus.datai;
        end
    end

    nps_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (ENTRY_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (wr_req & ~push);
    end

    // A marker shows as fo with vo low for one cycle and leaves datao untouched.
    always_comb begin
        vo_d    = vo_q;
        fo_d    = fo_q;
        datao_d = datao_q;
        if (pop) begin
            if (rd_entry[MARK_POS]) begin
                vo_d = 1'b0;
                fo_d = 1'b1;
            end else begin
                vo_d    = 1'b1;
                fo_d    = rd_entry[LAST_POS];
                datao_d = rd_entry[DATA_WIDTH-1:0];
            end
        end else if (out_free) begin
            vo_d = 1'b0;
            fo_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fi_prev_q <= 1'b0;
            ovf_q     <= 1'b0;
            vo_q      <= 1'b0;
            fo_q      <= 1'b0;
            datao_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fi_prev_q <= bus.fi;
            ovf_q     <= ovf_d;
            vo_q      <= vo_d;
            fo_q      <= fo_d;
            datao_q   <= datao_d;
        end
    end

    assign bus.vo    = vo_q;
    assign bus.fo    = fo_q;
    assign bus.datao = datao_q;
    assign bus.count = count_q;
    assign bus.full  = fifo_full;
    assign bus.ovf   = ovf_q;

endmodule
